// File: rtl/div_if.sv
// Handshake bundle between the EX stage (master) and the divider (slave).
// Carries operands, the start/annul controls and the {HI,LO} result.
interface div_if #(
    parameter int WIDTH = 32
);
    logic                   signed_div_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic                   start_i;
    logic                   annul_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, one quotient bit per clock.
// Optional feature macro: DIV_ANNUL_EN enables annul_i to abort an in-flight divide.
module div #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_dvd;      // remaining dividend bits, quotient shifts in at the LSB
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_rem;
    logic               r_signed;
    logic               r_neg1;
    logic               r_neg2;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic               w_annul;
    logic               w_start;
    logic               w_dvs_zero;
    logic               w_done;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH:0]     w_part;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

`ifdef DIV_ANNUL_EN
    assign w_annul = bus.annul_i;
`else
    logic w_unused_annul;
    assign w_unused_annul = bus.annul_i;
    assign w_annul        = 1'b0;
`endif

    assign w_start    = bus.start_i;
    assign w_dvs_zero = (bus.opdata2_i == '0);
    assign w_done     = (r_cnt == CW'(WIDTH));

    assign w_abs1 = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign w_abs2 = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

    // Remainder stays below the divisor, so one extra bit holds the shifted partial.
    assign w_part     = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff     = w_part - {1'b0, r_dvs};
    assign w_ge       = (w_part >= {1'b0, r_dvs});
    assign w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_part[WIDTH-1:0];

    assign w_quo_fix = (r_signed && (r_neg1 ^ r_neg2)) ? -r_dvd : r_dvd;
    assign w_rem_fix = (r_signed && r_neg1) ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FREE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FREE: begin
                if (w_start && !w_annul) w_next = w_dvs_zero ? S_BYZERO : S_ON;
            end
            S_BYZERO: w_next = w_annul ? S_FREE : S_END;
            S_ON: begin
                if (w_annul)     w_next = S_FREE;
                else if (w_done) w_next = S_END;
            end
            S_END: begin
                if (!w_start) w_next = S_FREE;
            end
            default: w_next = S_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_signed <= 1'b0;
            r_neg1   <= 1'b0;
            r_neg2   <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_FREE: begin
                    if (w_next == S_ON) begin
                        r_cnt    <= '0;
                        r_dvd    <= w_abs1;
                        r_dvs    <= w_abs2;
                        r_rem    <= '0;
                        r_signed <= bus.signed_div_i;
                        r_neg1   <= bus.opdata1_i[WIDTH-1];
                        r_neg2   <= bus.opdata2_i[WIDTH-1];
                    end
                end
                S_BYZERO: begin
                    if (w_annul) begin
                        r_cnt    <= '0;
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end else begin
                        r_result <= '0;
                        r_ready  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (w_annul) begin
                        r_cnt    <= '0;
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end else if (w_done) begin
                        r_result <= {w_rem_fix, w_quo_fix};
                        r_ready  <= 1'b1;
                    end else begin
                        r_rem <= w_rem_next;
                        r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_END: begin
                    if (!w_start) begin
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end
                end
                default: begin
                    r_result <= '0;
                    r_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;

endmodule

// File: tb/tb_div.sv
// Directed-vector bench for the radix-2 divider: latency, sign fix-up, divide by zero,
// END hold, operand isolation, mid-divide reset and (with DIV_ANNUL_EN) annul.
module tb_div;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    div_if #(.WIDTH(32)) bus ();

    div #(.WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Start at E0, hold start, expect ready at edge E<lat>, hold in END, then release.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat,
                           input int hold, input bit scramble);
        int first = 0;
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        tick();
        for (int k = 1; k <= 40 && first == 0; k++) begin
            tick();
            if (scramble && k == 5) begin
                bus.opdata1_i    = 32'h0000_0001;
                bus.opdata2_i    = 32'h0000_0000;
                bus.signed_div_i = ~sgn;
            end
            if (bus.ready_o) first = k;
        end
        chk({tag, "_lat"}, 64'(first), 64'(lat));
        chk({tag, "_res"}, bus.result_o, exp);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, "_hold_rdy"}, 64'(bus.ready_o), 64'd1);
            chk({tag, "_hold_res"}, bus.result_o, exp);
        end
        bus.start_i = 1'b0;
        tick();
        chk({tag, "_rel_rdy"}, 64'(bus.ready_o), 64'd0);
        chk({tag, "_rel_res"}, bus.result_o, 64'd0);
    endtask

    initial begin
        int first;
        logic [63:0] cap;
        rst              = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        tick();
        tick();
        chk("reset_rdy", 64'(bus.ready_o), 64'd0);
        chk("reset_res", bus.result_o, 64'd0);
        rst = 1'b0;
        tick();

        run_div("u100_7",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 33, 0, 0);
        run_div("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD},  33, 0, 0);
        run_div("s7_-2",    1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD},          33, 0, 0);
        run_div("s-8_-3",   1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  {32'hFFFF_FFFE, 32'd2},          33, 0, 0);
        run_div("s_zero",   1'b1, 32'hFFFF_FFF9,  32'd0,          64'd0,                           1,  0, 0);
        run_div("u_zero",   1'b0, 32'd12345,      32'd0,          64'd0,                           1,  0, 0);
        run_div("s_min_m1", 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0, 32'h8000_0000},          33, 0, 0);
        run_div("u_max_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0, 32'hFFFF_FFFF},          33, 0, 0);
        run_div("u_max_16", 1'b0, 32'hFFFF_FFFF,  32'h10,         {32'hF, 32'h0FFF_FFFF},          33, 0, 0);
        run_div("u_hold",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 33, 5, 0);
        run_div("u_scram",  1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 33, 0, 1);

        // Reset asserted at E15 of an in-flight divide.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        tick();
        for (int k = 1; k <= 14; k++) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_rdy", 64'(bus.ready_o), 64'd0);
        chk("rst_mid_res", bus.result_o, 64'd0);
        rst         = 1'b0;
        bus.start_i = 1'b0;
        first = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.ready_o) first = 1;
        end
        chk("rst_mid_quiet", 64'(first), 64'd0);
        run_div("u_after_rst", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33, 0, 0);

        // Annul pulse at E10; start dropped after E0 so a completed divide shows up only once.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd50;
        bus.opdata2_i    = 32'd5;
        bus.start_i      = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int k = 1; k <= 9; k++) tick();
        bus.annul_i = 1'b1;
        tick();
        bus.annul_i = 1'b0;
        chk("annul_e10_rdy", 64'(bus.ready_o), 64'd0);
        first = 0;
        cap   = '0;
        for (int k = 11; k <= 50; k++) begin
            tick();
            if (bus.ready_o && first == 0) begin
                first = k;
                cap   = bus.result_o;
            end
        end
`ifdef DIV_ANNUL_EN
        chk("annul_lat", 64'(first), 64'd0);
        chk("annul_res", cap, 64'd0);
`else
        chk("noannul_lat", 64'(first), 64'd33);
        chk("noannul_res", cap, {32'd0, 32'd10});
`endif
        chk("annul_idle_rdy", 64'(bus.ready_o), 64'd0);
        run_div("u9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
